// File: rtl/fa_addsub_lod_pkg.sv
// Shared widths for the significand add/subtract + leading-one stage.
package fa_addsub_lod_pkg;

  localparam int SG_W_DEF = 24;
  localparam int EX_W_DEF = 8;

  // The leading-one position must be able to name every bit of the significand.
  function automatic int lod_cnt_w(input int sg_w);
    return $clog2(sg_w);
  endfunction

  localparam int CNT_W_DEF = lod_cnt_w(SG_W_DEF);

endpackage

// File: rtl/fa_lod24.sv
// Combinational leading-one detector: index of the highest set bit of sum.
module fa_lod24
  import fa_addsub_lod_pkg::*;
#(
  parameter int SG_W  = SG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [SG_W-1:0]  sum,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    count = '0;
    zero  = 1'b1;
    for (int i = 0; i < SG_W; i++) begin
      if (sum[i]) begin
        count = CNT_W'(i);
        zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fa_addsub_lod.sv
// Two-stage significand add/subtract with leading-one detection for the FP adder.
module fa_addsub_lod
  import fa_addsub_lod_pkg::*;
#(
  parameter int SG_W  = SG_W_DEF,
  parameter int EX_W  = EX_W_DEF,
  parameter int CNT_W = lod_cnt_w(SG_W)
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [SG_W-1:0]  sg_a,
  input  logic [SG_W-1:0]  sg_b,
  input  logic [EX_W-1:0]  ex_in,
  output logic             out_valid,
  output logic             out_sign,
  output logic [EX_W-1:0]  current_ex,
  output logic [SG_W-1:0]  sum,
  output logic             ov,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [SG_W:0]     r_next;
  logic              sign_next;

  logic [SG_W:0]     s1_r;
  logic              s1_sign;
  logic [EX_W-1:0]   s1_ex;
  logic              s1_valid;

  logic [CNT_W-1:0]  lod_count;
  logic              lod_zero;
  logic [CNT_W-1:0]  count_next;
  logic              zero_next;

  // Magnitude add or subtract; subtraction always takes larger minus smaller
  // so it never carries, and an exact cancel yields +0.
  always_comb begin
    r_next    = '0;
    sign_next = 1'b0;
    if (sign_a == sign_b) begin
      r_next    = {1'b0, sg_a} + {1'b0, sg_b};
      sign_next = sign_a;
    end else if (sg_a > sg_b) begin
      r_next    = {1'b0, sg_a - sg_b};
      sign_next = sign_a;
    end else if (sg_b > sg_a) begin
      r_next    = {1'b0, sg_b - sg_a};
      sign_next = sign_b;
    end
  end

  // Stage 1 registers: raw magnitude result, sign, exponent and valid.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_r     <= '0;
      s1_sign  <= 1'b0;
      s1_ex    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_r     <= r_next;
      s1_sign  <= sign_next;
      s1_ex    <= ex_in;
      s1_valid <= in_valid;
    end
  end

  fa_lod24 #(
    .SG_W  (SG_W),
    .CNT_W (CNT_W)
  ) u_lod (
    .sum   (s1_r[SG_W-1:0]),
    .count (lod_count),
    .zero  (lod_zero)
  );

  // A carry out makes the implied MSB sit above sum, so it dominates the LOD.
  always_comb begin
    count_next = lod_count;
    zero_next  = lod_zero;
    if (s1_r[SG_W]) begin
      count_next = CNT_W'(SG_W - 1);
      zero_next  = 1'b0;
    end
  end

  // Stage 2 registers drive the outputs directly.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      current_ex <= '0;
      sum        <= '0;
      ov         <= 1'b0;
      count      <= '0;
      zero       <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      out_sign   <= s1_sign;
      current_ex <= s1_ex;
      sum        <= s1_r[SG_W-1:0];
      ov         <= s1_r[SG_W];
      count      <= count_next;
      zero       <= zero_next;
    end
  end

endmodule

// File: tb/tb_fa_addsub_lod.sv
// Scoreboard bench for fa_addsub_lod using directed, hand-computed vectors.
module tb_fa_addsub_lod;

  typedef struct packed {
    logic        sign;
    logic [7:0]  ex;
    logic [23:0] sum;
    logic        ov;
    logic [4:0]  count;
    logic        zero;
  } exp_t;

  logic        CLK;
  logic        RESETn;
  logic        in_valid;
  logic        sign_a;
  logic        sign_b;
  logic [23:0] sg_a;
  logic [23:0] sg_b;
  logic [7:0]  ex_in;
  logic        out_valid;
  logic        out_sign;
  logic [7:0]  current_ex;
  logic [23:0] sum;
  logic        ov;
  logic [4:0]  count;
  logic        zero;

  int   checks;
  int   errors;
  int   popped;
  int   pushed;
  exp_t exp_q[$];

  fa_addsub_lod dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .in_valid   (in_valid),
    .sign_a     (sign_a),
    .sign_b     (sign_b),
    .sg_a       (sg_a),
    .sg_b       (sg_b),
    .ex_in      (ex_in),
    .out_valid  (out_valid),
    .out_sign   (out_sign),
    .current_ex (current_ex),
    .sum        (sum),
    .ov         (ov),
    .count      (count),
    .zero       (zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one operation just after a rising edge; optionally expect its result.
  task automatic apply_stimulus(input logic v, input logic sa, input logic sb,
                                input logic [23:0] a, input logic [23:0] b,
                                input logic [7:0] e, input logic track, input exp_t want);
    @(posedge CLK);
    #1;
    in_valid = v;
    sign_a   = sa;
    sign_b   = sb;
    sg_a     = a;
    sg_b     = b;
    ex_in    = e;
    if (track) begin
      exp_q.push_back(want);
      pushed++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".out_valid"},  32'(out_valid),  32'h0);
    check_output({tag, ".out_sign"},   32'(out_sign),   32'h0);
    check_output({tag, ".current_ex"}, 32'(current_ex), 32'h0);
    check_output({tag, ".sum"},        32'(sum),        32'h0);
    check_output({tag, ".ov"},         32'(ov),         32'h0);
    check_output({tag, ".count"},      32'(count),      32'h0);
    check_output({tag, ".zero"},       32'(zero),       32'h0);
  endtask

  // Monitor: every valid output is matched in order against the scoreboard.
  always @(negedge CLK) begin
    exp_t got;
    exp_t want;
    if (RESETn && out_valid) begin
      got = '{sign: out_sign, ex: current_ex, sum: sum, ov: ov, count: count, zero: zero};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid: got sign=%b ex=%h sum=%h ov=%b count=%0d zero=%b, expected no output",
                 got.sign, got.ex, got.sum, got.ov, got.count, got.zero);
      end else begin
        want = exp_q.pop_front();
        popped++;
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL result%0d: got sign=%b ex=%h sum=%h ov=%b count=%0d zero=%b, expected sign=%b ex=%h sum=%h ov=%b count=%0d zero=%b",
                   popped, got.sign, got.ex, got.sum, got.ov, got.count, got.zero,
                   want.sign, want.ex, want.sum, want.ov, want.count, want.zero);
        end
      end
    end
  end

  initial begin
    exp_t none;
    int   wait_cycles;
    none        = '0;
    checks      = 0;
    errors      = 0;
    popped      = 0;
    pushed      = 0;
    RESETn      = 1'b0;
    in_valid    = 1'b0;
    sign_a      = 1'b0;
    sign_b      = 1'b0;
    sg_a        = '0;
    sg_b        = '0;
    ex_in       = '0;

    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RESETn = 1'b1;

    // Directed vectors: add with/without carry, subtracts, exact cancel.
    apply_stimulus(1, 0, 0, 24'h800000, 24'h800000, 8'h7F, 1, '{0, 8'h7F, 24'h000000, 1, 5'd23, 0});
    apply_stimulus(1, 0, 0, 24'h800000, 24'h400000, 8'h80, 1, '{0, 8'h80, 24'hC00000, 0, 5'd23, 0});
    apply_stimulus(1, 0, 1, 24'h800000, 24'h600000, 8'h81, 1, '{0, 8'h81, 24'h200000, 0, 5'd21, 0});
    apply_stimulus(1, 0, 1, 24'h400000, 24'hC00000, 8'h82, 1, '{1, 8'h82, 24'h800000, 0, 5'd23, 0});
    apply_stimulus(1, 1, 0, 24'h900000, 24'h900000, 8'h83, 1, '{0, 8'h83, 24'h000000, 0, 5'd0,  1});
    apply_stimulus(0, 0, 0, 24'h0,      24'h0,      8'h00, 0, none);
    apply_stimulus(0, 0, 0, 24'h0,      24'h0,      8'h00, 0, none);

    // Streaming: three back-to-back valid ops then a bubble.
    apply_stimulus(1, 0, 0, 24'h100000, 24'h000001, 8'h10, 1, '{0, 8'h10, 24'h100001, 0, 5'd20, 0});
    apply_stimulus(1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 8'h20, 1, '{1, 8'h20, 24'hFFFFFE, 1, 5'd23, 0});
    apply_stimulus(1, 1, 0, 24'h000003, 24'h000002, 8'h30, 1, '{1, 8'h30, 24'h000001, 0, 5'd0,  0});
    apply_stimulus(0, 0, 0, 24'h0,      24'h0,      8'h00, 0, none);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_output("bubble.out_valid", 32'(out_valid), 32'h0);

    // Two ops in flight, then an asynchronous reset between clock edges.
    apply_stimulus(1, 0, 0, 24'h123456, 24'h000111, 8'h55, 0, none);
    apply_stimulus(1, 0, 1, 24'h700000, 24'h100000, 8'h66, 0, none);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    #1;
    RESETn = 1'b0;
    #1;
    check_all_zero("async_reset");
    #1;
    RESETn = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      #1;
      check_output("post_reset.out_valid", 32'(out_valid), 32'h0);
    end

    // First op after reset release must come out normally.
    apply_stimulus(1, 0, 0, 24'h000001, 24'h000001, 8'h01, 1, '{0, 8'h01, 24'h000002, 0, 5'd1, 0});
    apply_stimulus(0, 0, 0, 24'h0,      24'h0,      8'h00, 0, none);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 20) begin
      @(posedge CLK);
      wait_cycles++;
    end
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check_output("drain.pending", 32'(exp_q.size()), 32'h0);
    check_output("drain.popped", 32'(popped), 32'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fa_addsub_lod.md
Name: fa_addsub_lod

Overview:
Significand add/subtract and leading-one detection stage of the floating-point adder in the MAC datapath. It sits directly upstream of the normalize/round stage. It takes exponent-aligned 24-bit significands with their signs and the common exponent. It produces the magnitude sum, the carry-out flag, the leading-one position and the result sign, which the downstream stage uses to normalize and round. It is a two-stage pipeline with a valid bit travelling alongside the data.

Parameters:
SG_W, 24, significand width including hidden bit
EX_W, 8, exponent width
CNT_W, 5, leading-one position width; must satisfy 2^CNT_W >= SG_W

Ports:
CLK  input  1  clock, rising edge
RESETn  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle
sign_a  input  1  sign of operand A
sign_b  input  1  sign of operand B
sg_a  input  SG_W  aligned significand A
sg_b  input  SG_W  aligned significand B
ex_in  input  EX_W  common (larger) exponent after alignment
out_valid  output  1  outputs below are valid
out_sign  output  1  result sign
current_ex  output  EX_W  exponent, passed through unchanged
sum  output  SG_W  low SG_W bits of the magnitude result
ov  output  1  carry out of the SG_W-bit add
count  output  CNT_W  bit index of the leading one of sum
zero  output  1  magnitude result is exactly zero

Behaviour:
- Reset: when RESETn goes low, all pipeline registers and all outputs clear to 0 immediately, regardless of the clock. This includes out_valid, out_sign, current_ex, sum, ov, count and zero. Any in-flight operation is discarded.
- Pipeline: the stage is free-running with no backpressure. Every cycle, both stages advance. Latency is exactly 2 cycles from in_valid to out_valid. Throughput is 1 operation per cycle.
- Invalid input: a cycle with in_valid=0 still moves the data registers forward, but the associated valid bit is 0. Downstream logic ignores the data when out_valid=0.
- Stage 1, same signs (sign_a == sign_b):
  - r = sg_a + sg_b, computed at width SG_W+1.
  - Result sign = sign_a.
- Stage 1, different signs:
  - Compare the magnitudes of sg_a and sg_b.
  - r = larger - smaller.
  - Result sign = sign of the larger operand.
  - If the magnitudes are equal, r = 0 and the sign is forced to 0.
- Stage 1 registers r (SG_W+1 bits), the result sign, ex_in and the valid bit.
- Stage 2 outputs:
  - ov = r[SG_W].
  - sum = r[SG_W-1:0].
  - out_sign and current_ex are the registered copies from stage 1.
- Stage 2, count rule:
  - If ov=1: count = SG_W-1.
  - Else if sum != 0: count = the highest index i with sum[i]=1, in the range 0..SG_W-1.
  - Else: count = 0 and zero = 1.
  - zero = 0 in every other case.
- Width rules:
  - The subtraction never produces a carry, so ov=0 on every subtract path.
  - The add carry is never dropped.
  - count is unsigned.
- Downstream contract:
  - When ov=0, the next stage shifts sum left by (SG_W-1-count) and sets exponent = current_ex-(SG_W-1)+count.
  - When ov=1, the carry is the implied MSB and sum[0] is the round bit.
  - A zero result has ov=0, count=0, zero=1 and out_sign=0.
- Back-to-back operations must not interfere with each other: each has its own stage registers.

Decomposition:
- Shared package holds the SG_W and EX_W defaults and the CNT_W derivation.
- The leading-one detector is one natural sub-module, fa_lod24. It is purely combinational: sum[SG_W-1:0] in, count and zero out. The pipeline registers stay in the parent.

Test Plan:
- Add with carry: sign_a=sign_b=0, sg_a=sg_b=0x800000, ex_in=0x7F, in_valid=1 -> 2 cycles later out_valid=1, sum=0x000000, ov=1, count=23, zero=0, out_sign=0, current_ex=0x7F.
- Add without carry: sign 0/0, sg_a=0x800000, sg_b=0x400000, ex_in=0x80 -> sum=0xC00000, ov=0, count=23, current_ex=0x80.
- Subtract with cancellation: sign_a=0, sg_a=0x800000, sign_b=1, sg_b=0x600000 -> sum=0x200000, ov=0, count=21, out_sign=0.
- Subtract with operand swap: sign_a=0, sg_a=0x400000, sign_b=1, sg_b=0xC00000 -> sum=0x800000, count=23, out_sign=1, ov=0.
- Exact cancel: sign_a=1, sign_b=0, sg_a=sg_b=0x900000 -> sum=0, zero=1, count=0, out_sign=0, ov=0.
- Streaming and reset: three consecutive valid inputs, then a bubble -> out_valid pattern 1,1,1,0 with results in order. Drop RESETn with 2 results in flight -> every output reads 0 before the next CLK edge, and out_valid stays 0 until 2 cycles after the next in_valid following release.
